// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> T0..T2 (-> T3) -> EXEC -> T0 / HALTED, with a sticky halt request.
// Optional macro FETCH_INDIRECT_EN adds the T3 indirect-address cycle; without it T2 always goes to EXEC.
module fetch_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    input  logic        mem_ready,
    input  logic [15:0] ir_in,
    input  logic        exec_done,
    output logic        load_ar,
    output logic [1:0]  ar_sel,
    output logic        mem_read,
    output logic        load_ir,
    output logic        inc_pc,
    output logic        i_flag,
    output logic [2:0]  opcode,
    output logic        exec_active,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T0     = 3'd1,
        S_T1     = 3'd2,
        S_T2     = 3'd3,
`ifdef FETCH_INDIRECT_EN
        S_T3     = 3'd4,
`endif
        S_EXEC   = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_IR  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // The address field feeds the AR mux in the datapath; the sequencer only steers it.
    localparam int AR_FIELD_W = (WIDTH < 12) ? WIDTH : 12;

    state_t state_r;
    state_t next_state_s;
    logic   halt_latch_r;
    logic   halt_latch_next_s;
    logic   [AR_FIELD_W-1:0] addr_field_unused_s;

    assign addr_field_unused_s = ir_in[AR_FIELD_W-1:0];

`ifdef FETCH_INDIRECT_EN
    logic indirect_s;
    // Opcode 111 is the register/IO group, which never takes the indirect cycle.
    assign indirect_s = ir_in[15] && (ir_in[14:12] != 3'b111);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    next_state_s = S_T0;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_T0: begin
                next_state_s = S_T1;
            end
            S_T1: begin
                if (mem_ready) begin
                    next_state_s = S_T2;
                end else begin
                    next_state_s = S_T1;
                end
            end
            S_T2: begin
`ifdef FETCH_INDIRECT_EN
                if (indirect_s) begin
                    next_state_s = S_T3;
                end else begin
                    next_state_s = S_EXEC;
                end
`else
                next_state_s = S_EXEC;
`endif
            end
`ifdef FETCH_INDIRECT_EN
            S_T3: begin
                if (mem_ready) begin
                    next_state_s = S_EXEC;
                end else begin
                    next_state_s = S_T3;
                end
            end
`endif
            S_EXEC: begin
                if (!exec_done) begin
                    next_state_s = S_EXEC;
                end else if (halt_latch_r || halt) begin
                    next_state_s = S_HALTED;
                end else begin
                    next_state_s = S_T0;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Halt request: sticky until the sequencer restarts out of HALTED.
    always_comb begin
        halt_latch_next_s = halt_latch_r;
        if ((state_r == S_HALTED) && start) begin
            halt_latch_next_s = 1'b0;
        end else begin
            halt_latch_next_s = halt_latch_r | halt;
        end
    end

    // Halt latch register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt_latch_r <= 1'b0;
        end else begin
            halt_latch_r <= halt_latch_next_s;
        end
    end

    // Instruction decode captured while the IR contents are presented in T2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_flag <= 1'b0;
            opcode <= 3'b000;
        end else if (state_r == S_T2) begin
            i_flag <= ir_in[15];
            opcode <= ir_in[14:12];
        end else begin
            i_flag <= i_flag;
            opcode <= opcode;
        end
    end

    // Strobe decode from the state register and the memory handshake.
    always_comb begin
        load_ar     = 1'b0;
        ar_sel      = SEL_PC;
        mem_read    = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        exec_active = 1'b0;
        busy        = 1'b1;
        case (state_r)
            S_IDLE, S_HALTED: begin
                busy = 1'b0;
            end
            S_T0: begin
                load_ar = 1'b1;
                ar_sel  = SEL_PC;
            end
            S_T1: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end else begin
                    load_ir = 1'b0;
                    inc_pc  = 1'b0;
                end
            end
            S_T2: begin
                load_ar = 1'b1;
                ar_sel  = SEL_IR;
            end
`ifdef FETCH_INDIRECT_EN
            S_T3: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    load_ar = 1'b1;
                    ar_sel  = SEL_MEM;
                end else begin
                    load_ar = 1'b0;
                    ar_sel  = SEL_PC;
                end
            end
`endif
            S_EXEC: begin
                exec_active = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer; expectations adapt to FETCH_INDIRECT_EN.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        mem_ready;
    logic [15:0] ir_in;
    logic        exec_done;
    logic        load_ar;
    logic [1:0]  ar_sel;
    logic        mem_read;
    logic        load_ir;
    logic        inc_pc;
    logic        i_flag;
    logic [2:0]  opcode;
    logic        exec_active;
    logic        busy;

    fetch_sequencer #(.WIDTH(12)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .mem_ready(mem_ready), .ir_in(ir_in), .exec_done(exec_done),
        .load_ar(load_ar), .ar_sel(ar_sel), .mem_read(mem_read),
        .load_ir(load_ir), .inc_pc(inc_pc), .i_flag(i_flag), .opcode(opcode),
        .exec_active(exec_active), .busy(busy)
    );

    // Output patterns: {load_ar, ar_sel[1:0], mem_read, load_ir, inc_pc, exec_active, busy}
    localparam logic [7:0] P_IDLE = 8'b0_00_0_0_0_0_0;
    localparam logic [7:0] P_T0   = 8'b1_00_0_0_0_0_1;
    localparam logic [7:0] P_T1W  = 8'b0_00_1_0_0_0_1;
    localparam logic [7:0] P_T1R  = 8'b0_00_1_1_1_0_1;
    localparam logic [7:0] P_T2   = 8'b1_01_0_0_0_0_1;
    localparam logic [7:0] P_T3W  = 8'b0_00_1_0_0_0_1;
    localparam logic [7:0] P_T3R  = 8'b1_10_1_0_0_0_1;
    localparam logic [7:0] P_EXEC = 8'b0_00_0_0_0_1_1;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] snapshot();
        return {i_flag, opcode, load_ar, ar_sel, mem_read, load_ir, inc_pc, exec_active, busy};
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] dec, input logic [7:0] pat);
        exp_t e;
        e.tag = tag;
        e.v   = {dec, pat};
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [11:0] obs;
        obs = snapshot();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check the Moore outputs before the rising edge.
    task automatic cyc(input string tag, input logic st, input logic hl, input logic mr,
                       input logic ed, input logic [3:0] dec, input logic [7:0] pat);
        @(negedge clk);
        start     = st;
        halt      = hl;
        mem_ready = mr;
        exec_done = ed;
        expect_out(tag, dec, pat);
        #2;
        check_now();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        mem_ready = 1'b0;
        exec_done = 1'b0;
        ir_in     = 16'h2123;
        #2;
        expect_out("reset", 4'h0, P_IDLE);
        check_now();
        @(negedge clk);
        reset_n = 1'b1;

        // Direct instruction 2123: T0,T1,T2,EXEC, done on the 2nd EXEC cycle.
        cyc("idle",          1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_IDLE);
        cyc("idle_start",    1'b1, 1'b0, 1'b1, 1'b0, 4'h0, P_IDLE);
        cyc("t0",            1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T0);
        cyc("t1",            1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T1R);
        cyc("t2",            1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T2);
        cyc("exec1",         1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_EXEC);
        cyc("exec2",         1'b0, 1'b0, 1'b1, 1'b1, 4'h2, P_EXEC);
        cyc("t0_again",      1'b0, 1'b0, 1'b0, 1'b0, 4'h2, P_T0);

        // Memory wait in T1 (stray start/exec_done ignored), then F800 goes straight to EXEC.
        ir_in = 16'hF800;
        for (int i = 0; i < 5; i++) begin
            cyc("t1_wait", (i == 2), 1'b0, 1'b0, (i == 3), 4'h2, P_T1W);
        end
        cyc("t1_ready",      1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T1R);
        cyc("t2_f800",       1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T2);
        cyc("exec_f800",     1'b0, 1'b0, 1'b1, 1'b1, 4'hF, P_EXEC);

        // Indirect A050.
        ir_in = 16'hA050;
        cyc("t0_a050",       1'b0, 1'b0, 1'b1, 1'b0, 4'hF, P_T0);
        cyc("t1_a050",       1'b0, 1'b0, 1'b1, 1'b0, 4'hF, P_T1R);
        cyc("t2_a050",       1'b0, 1'b0, 1'b1, 1'b0, 4'hF, P_T2);
`ifdef FETCH_INDIRECT_EN
        cyc("t3_a050",       1'b0, 1'b0, 1'b1, 1'b0, 4'hA, P_T3R);
`endif
        cyc("exec_a050",     1'b0, 1'b0, 1'b1, 1'b1, 4'hA, P_EXEC);

        // Halt pulsed in T1: instruction completes, then HALTED until start.
        ir_in = 16'h2123;
        cyc("t0_h",          1'b0, 1'b0, 1'b1, 1'b0, 4'hA, P_T0);
        cyc("t1_h",          1'b0, 1'b1, 1'b1, 1'b0, 4'hA, P_T1R);
        cyc("t2_h",          1'b0, 1'b0, 1'b1, 1'b0, 4'hA, P_T2);
        cyc("exec_h",        1'b0, 1'b0, 1'b1, 1'b1, 4'h2, P_EXEC);
        cyc("halted",        1'b0, 1'b0, 1'b1, 1'b1, 4'h2, P_IDLE);
        cyc("halted_start",  1'b1, 1'b0, 1'b1, 1'b0, 4'h2, P_IDLE);
        cyc("t0_resume",     1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T0);
        cyc("t1_resume",     1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T1R);
        cyc("t2_resume",     1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T2);
        cyc("exec_resume",   1'b0, 1'b0, 1'b1, 1'b1, 4'h2, P_EXEC);
        cyc("t0_latch_clr",  1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T0);

        // Halt in the same cycle as exec_done.
        cyc("t1_same",       1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T1R);
        cyc("t2_same",       1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T2);
        cyc("exec_same",     1'b0, 1'b1, 1'b1, 1'b1, 4'h2, P_EXEC);
        cyc("halted_same",   1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_IDLE);
        cyc("halted_start2", 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, P_IDLE);
        cyc("t0_after_halt", 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T0);

        // Asynchronous reset mid-instruction, with a pending halt that reset must discard.
        ir_in = 16'hA050;
        cyc("t1_rst",        1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T1R);
        cyc("t2_rst",        1'b0, 1'b1, 1'b1, 1'b0, 4'h2, P_T2);
`ifdef FETCH_INDIRECT_EN
        cyc("t3_wait_rst",   1'b0, 1'b0, 1'b0, 1'b0, 4'hA, P_T3W);
`else
        cyc("exec_wait_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, P_EXEC);
`endif
        #1;
        reset_n = 1'b0;
        #1;
        expect_out("async_reset", 4'h0, P_IDLE);
        check_now();
        @(posedge clk);
        #2;
        expect_out("reset_hold", 4'h0, P_IDLE);
        check_now();
        @(negedge clk);
        reset_n = 1'b1;
        ir_in   = 16'h2123;
        for (int i = 0; i < 3; i++) begin
            cyc("idle_after_rst", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, P_IDLE);
        end
        cyc("restart",       1'b1, 1'b0, 1'b1, 1'b0, 4'h0, P_IDLE);
        cyc("t0_restart",    1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T0);
        cyc("t1_restart",    1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T1R);
        cyc("t2_restart",    1'b0, 1'b0, 1'b1, 1'b0, 4'h0, P_T2);
        cyc("exec_restart",  1'b0, 1'b0, 1'b1, 1'b1, 4'h2, P_EXEC);
        cyc("t0_no_halt",    1'b0, 1'b0, 1'b1, 1'b0, 4'h2, P_T0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
